// File: rtl/vmicro16_branch_unit.sv
// NZCV flags holder and branch resolver: redirect valid one cycle after the branch resolves (accept, or pending drop while waiting).
// br_ready is high only in IDLE; a redirect is held stable until fetch acks it.
module vmicro16_branch_unit #(
    parameter int DATA_WIDTH  = 16,
    parameter int FLAGS_WIDTH = 4,
    parameter int COND_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flags_we,
    input  logic [FLAGS_WIDTH-1:0] flags_in,
    input  logic                   flags_pending,
    input  logic                   br_valid,
    output logic                   br_ready,
    input  logic [COND_WIDTH-1:0]  br_cond,
    input  logic [DATA_WIDTH-1:0]  br_target,
    input  logic [DATA_WIDTH-1:0]  br_pc_next,
    output logic [FLAGS_WIDTH-1:0] flags,
    output logic                   redir_valid,
    output logic [DATA_WIDTH-1:0]  redir_pc,
    output logic                   redir_taken,
    input  logic                   redir_ack,
    output logic                   flush
);

    // Condition encodings shared with the ALU SETC operation.
    localparam logic [COND_WIDTH-1:0] BR_U  = COND_WIDTH'(8'h00);
    localparam logic [COND_WIDTH-1:0] BR_E  = COND_WIDTH'(8'h01);
    localparam logic [COND_WIDTH-1:0] BR_NE = COND_WIDTH'(8'h02);
    localparam logic [COND_WIDTH-1:0] BR_G  = COND_WIDTH'(8'h03);
    localparam logic [COND_WIDTH-1:0] BR_L  = COND_WIDTH'(8'h05);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [FLAGS_WIDTH-1:0] flags_q;
    logic [COND_WIDTH-1:0]  cond_q, cond_d;
    logic [DATA_WIDTH-1:0]  target_q, target_d;
    logic [DATA_WIDTH-1:0]  pcn_q, pcn_d;
    logic [DATA_WIDTH-1:0]  redir_pc_q, redir_pc_d;
    logic                   redir_taken_q, redir_taken_d;
    logic                   flush_q, flush_d;

    logic                   eff_n, eff_z, eff_v;
    logic [COND_WIDTH-1:0]  sel_cond;
    logic [DATA_WIDTH-1:0]  sel_target, sel_pcn;
    logic                   taken_c;

    function automatic logic cond_eval(input logic [COND_WIDTH-1:0] c,
                                       input logic n, input logic z, input logic v);
        logic r;
        r = 1'b0;
        case (c)
            BR_U:    r = 1'b1;
            BR_E:    r = z;
            BR_NE:   r = !z;
            BR_G:    r = !z && (n == v);
            BR_L:    r = z || (n != v);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // A flag write in the resolving cycle is bypassed so the branch sees it.
    assign eff_n = flags_we ? flags_in[3] : flags_q[3];
    assign eff_z = flags_we ? flags_in[2] : flags_q[2];
    assign eff_v = flags_we ? flags_in[0] : flags_q[0];

    assign sel_cond   = (state_q == S_WAIT) ? cond_q   : br_cond;
    assign sel_target = (state_q == S_WAIT) ? target_q : br_target;
    assign sel_pcn    = (state_q == S_WAIT) ? pcn_q    : br_pc_next;
    assign taken_c    = cond_eval(sel_cond, eff_n, eff_z, eff_v);

    always_comb begin
        state_d       = state_q;
        cond_d        = cond_q;
        target_d      = target_q;
        pcn_d         = pcn_q;
        redir_pc_d    = redir_pc_q;
        redir_taken_d = redir_taken_q;
        flush_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (br_valid) begin
                    cond_d   = br_cond;
                    target_d = br_target;
                    pcn_d    = br_pc_next;
                    if (!flags_pending || br_cond == BR_U) begin
                        state_d       = S_ISSUE;
                        redir_taken_d = taken_c;
                        redir_pc_d    = taken_c ? sel_target : sel_pcn;
                        flush_d       = taken_c;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!flags_pending) begin
                    state_d       = S_ISSUE;
                    redir_taken_d = taken_c;
                    redir_pc_d    = taken_c ? sel_target : sel_pcn;
                    flush_d       = taken_c;
                end
            end
            S_ISSUE: begin
                if (redir_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            flags_q       <= '0;
            cond_q        <= '0;
            target_q      <= '0;
            pcn_q         <= '0;
            redir_pc_q    <= '0;
            redir_taken_q <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cond_q        <= cond_d;
            target_q      <= target_d;
            pcn_q         <= pcn_d;
            redir_pc_q    <= redir_pc_d;
            redir_taken_q <= redir_taken_d;
            flush_q       <= flush_d;
            if (flags_we) begin
                flags_q <= flags_in;
            end
        end
    end

    assign br_ready    = (state_q == S_IDLE);
    assign redir_valid = (state_q == S_ISSUE);
    assign redir_pc    = redir_pc_q;
    assign redir_taken = redir_taken_q;
    assign flush       = flush_q;
    assign flags       = flags_q;

endmodule

// File: tb/tb_vmicro16_branch_unit.sv
// Directed and randomized branch transactions checked against a transaction-level model of the flags and condition rules.
module tb_vmicro16_branch_unit;

    localparam logic [7:0] C_U  = 8'h00;
    localparam logic [7:0] C_E  = 8'h01;
    localparam logic [7:0] C_NE = 8'h02;
    localparam logic [7:0] C_G  = 8'h03;
    localparam logic [7:0] C_L  = 8'h05;

    logic        clk = 1'b0;
    logic        reset;
    logic        flags_we;
    logic [3:0]  flags_in;
    logic        flags_pending;
    logic        br_valid;
    logic        br_ready;
    logic [7:0]  br_cond;
    logic [15:0] br_target;
    logic [15:0] br_pc_next;
    logic [3:0]  flags;
    logic        redir_valid;
    logic [15:0] redir_pc;
    logic        redir_taken;
    logic        redir_ack;
    logic        flush;

    int         total = 0;
    int         bad   = 0;
    logic [3:0] mflags;

    always #5 clk = ~clk;

    vmicro16_branch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .flags_we      (flags_we),
        .flags_in      (flags_in),
        .flags_pending (flags_pending),
        .br_valid      (br_valid),
        .br_ready      (br_ready),
        .br_cond       (br_cond),
        .br_target     (br_target),
        .br_pc_next    (br_pc_next),
        .flags         (flags),
        .redir_valid   (redir_valid),
        .redir_pc      (redir_pc),
        .redir_taken   (redir_taken),
        .redir_ack     (redir_ack),
        .flush         (flush)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: N at bit 3, Z at bit 2, V at bit 0; "less" means N and V disagree.
    function automatic logic ref_taken(input logic [7:0] c, input logic [3:0] f);
        logic zero, less;
        zero = f[2];
        less = f[3] ^ f[0];
        if (c == C_U)  return 1'b1;
        if (c == C_E)  return zero;
        if (c == C_NE) return !zero;
        if (c == C_G)  return !zero && !less;
        if (c == C_L)  return zero || less;
        return 1'b0;
    endfunction

    task automatic set_flags(input logic [3:0] v);
        flags_we = 1'b1;
        flags_in = v;
        tick();
        mflags   = v;
        flags_we = 1'b0;
    endtask

    // pend: cycles flags_pending is high starting with the accept cycle.
    // wr/wv: flag write in the resolving cycle (accept cycle or pending-drop cycle).
    task automatic run_br(input logic [7:0] c, input logic [15:0] tgt, input logic [15:0] pcn,
                          input int pend, input logic wr, input logic [3:0] wv, input int hold);
        logic        waitn;
        logic [3:0]  effv;
        logic        tk;
        logic [15:0] epc;
        waitn = (pend > 0) && (c != C_U);
        chk("ready_idle", br_ready, 1);
        br_valid      = 1'b1;
        br_cond       = c;
        br_target     = tgt;
        br_pc_next    = pcn;
        flags_pending = (pend > 0);
        flags_we      = !waitn && wr;
        flags_in      = wv;
        effv          = (!waitn && wr) ? wv : mflags;
        tick();
        if (!waitn && wr) mflags = wv;
        br_valid = 1'b0;
        flags_we = 1'b0;
        if (waitn) begin
            flags_pending = 1'b1;
            for (int i = 1; i < pend; i++) begin
                chk("ready_wait", br_ready, 0);
                chk("valid_wait", redir_valid, 0);
                tick();
            end
            flags_pending = 1'b0;
            flags_we      = wr;
            flags_in      = wv;
            chk("ready_drop", br_ready, 0);
            chk("valid_drop", redir_valid, 0);
            effv = wr ? wv : mflags;
            tick();
            if (wr) mflags = wv;
            flags_we = 1'b0;
        end
        flags_pending = 1'b0;
        tk  = ref_taken(c, effv);
        epc = tk ? tgt : pcn;
        chk("valid_issue", redir_valid, 1);
        chk("pc_issue", redir_pc, epc);
        chk("taken_issue", redir_taken, tk);
        chk("flush_first", flush, tk);
        chk("ready_issue", br_ready, 0);
        chk("flags_issue", flags, mflags);
        for (int h = 0; h < hold; h++) begin
            // A new request while busy must be ignored.
            br_valid  = 1'b1;
            br_target = ~tgt;
            br_pc_next = ~pcn;
            flags_we  = 1'($urandom_range(0, 1));
            flags_in  = 4'($urandom);
            tick();
            if (flags_we) mflags = flags_in;
            flags_we = 1'b0;
            chk("valid_hold", redir_valid, 1);
            chk("pc_hold", redir_pc, epc);
            chk("flush_hold", flush, 0);
            chk("flags_hold", flags, mflags);
        end
        br_valid  = 1'b0;
        redir_ack = 1'b1;
        tick();
        redir_ack = 1'b0;
        chk("valid_after_ack", redir_valid, 0);
        chk("ready_after_ack", br_ready, 1);
        chk("flush_after_ack", flush, 0);
    endtask

    initial begin
        reset = 1'b1; flags_we = 1'b0; flags_in = 4'h0; flags_pending = 1'b0;
        br_valid = 1'b0; br_cond = 8'h0; br_target = 16'h0; br_pc_next = 16'h0;
        redir_ack = 1'b0; mflags = 4'h0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready", br_ready, 1);
        chk("rst_valid", redir_valid, 0);
        chk("rst_pc", redir_pc, 0);
        chk("rst_taken", redir_taken, 0);
        chk("rst_flush", flush, 0);
        chk("rst_flags", flags, 0);

        // Equal, taken
        set_flags(4'b0100);
        chk("flags_written", flags, 4'b0100);
        run_br(C_E, 16'h0040, 16'h0012, 0, 1'b0, 4'h0, 1);
        // Greater: taken on 0000, not on Z
        set_flags(4'b0000);
        run_br(C_G, 16'h0100, 16'h0022, 0, 1'b0, 4'h0, 0);
        set_flags(4'b0100);
        run_br(C_G, 16'h0100, 16'h0022, 0, 1'b0, 4'h0, 0);
        // Less: Z, N!=V, neither
        run_br(C_L, 16'h0200, 16'h0034, 0, 1'b0, 4'h0, 0);
        set_flags(4'b1000);
        run_br(C_L, 16'h0200, 16'h0034, 0, 1'b0, 4'h0, 0);
        set_flags(4'b0000);
        run_br(C_L, 16'h0200, 16'h0034, 0, 1'b0, 4'h0, 0);
        // Hazard: 3 pending cycles, Z written via bypass in drop cycle
        run_br(C_E, 16'h0300, 16'h0044, 3, 1'b1, 4'b0100, 0);
        // Unconditional ignores pending; long hold
        run_br(C_U, 16'h0400, 16'h0056, 2, 1'b0, 4'h0, 4);
        // Undefined code, same-cycle bypass on accept
        run_br(8'h04, 16'h0500, 16'h0066, 0, 1'b1, 4'b0100, 0);
        run_br(C_NE, 16'h0600, 16'h0078, 0, 1'b1, 4'b0000, 1);

        // Reset during WAIT
        set_flags(4'b0101);
        br_valid = 1'b1; br_cond = C_E; br_target = 16'h0700; br_pc_next = 16'h0088;
        flags_pending = 1'b1;
        tick();
        br_valid = 1'b0;
        tick();
        chk("wait_ready", br_ready, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0; flags_pending = 1'b0; mflags = 4'h0;
        chk("rstw_ready", br_ready, 1);
        chk("rstw_valid", redir_valid, 0);
        chk("rstw_flags", flags, 0);
        chk("rstw_flush", flush, 0);
        tick();
        chk("rstw_stay_idle", redir_valid, 0);

        // Reset during ISSUE
        set_flags(4'b1111);
        br_valid = 1'b1; br_cond = C_U; br_target = 16'h0800; br_pc_next = 16'h0099;
        tick();
        br_valid = 1'b0;
        chk("iss_valid", redir_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0; mflags = 4'h0;
        chk("rsti_ready", br_ready, 1);
        chk("rsti_valid", redir_valid, 0);
        chk("rsti_flags", flags, 0);
        chk("rsti_flush", flush, 0);

        // Randomized transactions
        for (int n = 0; n < 60; n++) begin
            logic [7:0] c;
            c = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 2) == 0) set_flags(4'($urandom));
            run_br(c, 16'($urandom), 16'($urandom), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 4'($urandom), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vmicro16_branch_unit.md
Name: vmicro16_branch_unit

Overview:
- Branch-resolution stage that sits directly upstream of the fetch/PC logic and alongside the ALU.
- Holds the architectural NZCV flags register, written by compare/arithmetic results from the execute stage.
- Evaluates the same condition codes the ALU SETC operation uses, waits out any in-flight flag writer, then issues a PC redirect plus pipeline flush to fetch over a valid/ack handshake.

Parameters:
DATA_WIDTH, 16, width of PC and branch target.
FLAGS_WIDTH, 4, flags width; bit order N,Z,C,V = [3:0].
COND_WIDTH, 8, width of condition field; values are the VMICRO16_OP_BR_* constants from vmicro16_isa.v.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
flags_we  input  1  execute stage writes flags this cycle.
flags_in  input  FLAGS_WIDTH  new NZCV value.
flags_pending  input  1  an older instruction that will write flags is still in flight.
br_valid  input  1  branch request present.
br_ready  output  1  unit accepts request when high.
br_cond  input  COND_WIDTH  condition code (BR_U, BR_E, BR_NE, BR_G, BR_L).
br_target  input  DATA_WIDTH  taken target address.
br_pc_next  input  DATA_WIDTH  fall-through address.
flags  output  FLAGS_WIDTH  current architectural flags.
redir_valid  output  1  redirect request to fetch.
redir_pc  output  DATA_WIDTH  redirect address.
redir_taken  output  1  1 = target used, 0 = fall-through.
redir_ack  input  1  fetch consumed redirect.
flush  output  1  one-cycle pulse to squash younger instructions.

Behaviour:
- Reset values (synchronous, on the clock edge while reset=1): flags=0, state=IDLE, br_ready=1, redir_valid=0, redir_pc=0, redir_taken=0, flush=0.
- Flags register: flags <= flags_in on any clock edge with flags_we=1, in every state.
- Condition function eval(f):
  - BR_U = 1.
  - BR_E = Z.
  - BR_NE = !Z.
  - BR_G = !Z & (N==V).
  - BR_L = Z | (N!=V) (inclusive).
  - Any other code = 0 (not taken).
- Effective flags: flags_in when flags_we=1 in the same cycle (bypass), else the flags register.
- FSM states: IDLE, WAIT, ISSUE.
- IDLE: br_ready=1. Handshake occurs when br_valid & br_ready; latch cond, target and pc_next.
  - If flags_pending=0 and br_cond != BR_U requires no wait: evaluate immediately with effective flags and go to ISSUE next cycle.
  - BR_U never waits, even when flags_pending=1.
  - If flags_pending=1 and the condition is not BR_U: go to WAIT.
- WAIT: br_ready=0.
  - Each cycle with flags_pending=0: evaluate with effective flags, go to ISSUE.
  - No timeout.
- ISSUE: br_ready=0, redir_valid=1.
  - redir_pc = taken ? target : pc_next; redir_taken = taken. Both stay stable while redir_valid=1.
  - flush=1 only in the first ISSUE cycle, and only when taken.
  - On redir_ack=1: go to IDLE; redir_valid=0 next cycle.
- Latency: request accepted at edge T with no hazard gives redir_valid high from T+1. With a hazard, redir_valid goes high 1 cycle after the cycle in which flags_pending=0 is observed.
- Not-taken branches still issue a redirect with redir_pc=pc_next; fetch may ignore it. flush stays 0.
- br_valid while not ready: ignored; the requester holds the request.
- Reset mid-operation: abandons WAIT/ISSUE, returns to IDLE, drops redir_valid, clears flags.
- Simultaneous flags_we and evaluation: bypassed flags_in is used, and the register updates on the same edge.
- Arithmetic: none on addresses; values pass through unmodified at DATA_WIDTH.

Test Plan:
- Reset, then flags_we=1 with flags_in=4'b0100, then BR_E, target=16'h0040, pc_next=16'h0012 -> next cycle redir_valid=1, redir_pc=16'h0040, taken=1, flush=1 for one cycle; ack returns to IDLE with br_ready=1.
- flags=4'b0000, BR_G, target=16'h0100 -> taken, redir_pc=16'h0100. Same request with flags=4'b0100 -> not taken, redir_pc=pc_next, flush=0.
- flags=4'b0100, BR_L -> taken. flags=4'b1000 (N!=V) -> taken. flags=4'b0000 -> not taken.
- flags=0, flags_pending=1 for 3 cycles with BR_E; flags_we=1, flags_in=4'b0100 in the cycle pending drops -> br_ready=0 throughout, redirect is taken via bypass, redir_valid rises exactly 1 cycle after pending=0.
- BR_U with flags_pending=1 -> no wait; redir_valid next cycle. Hold redir_ack=0 for 4 cycles -> redir_pc stable, flush high only in the first cycle.
- Assert reset during WAIT and during ISSUE -> next cycle state IDLE, redir_valid=0, flags=0, br_ready=1.
